// File: rtl/rgmii_tx_ddr_sched_pkg.sv
// Shared definitions for the RGMII transmit DDR scheduler: speed encodings,
// nibble order on the wire and the counter width used by the TXC phase logic.
package rgmii_tx_ddr_sched_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } speed_e;

    // Low nibble leaves first (rising edge / first TXC period), high nibble second.
    localparam int NIB_FIRST_LSB  = 0;
    localparam int NIB_SECOND_LSB = 4;

    // Wide enough for cnt up to 127, so 2*cnt+1 fits in CNT_W+1 bits.
    localparam int CNT_W = 7;

    // 2'b11 is an alias of 1000M; fold it so speed_act only shows the three legal codes.
    function automatic speed_e norm_speed(input logic [1:0] s);
        case (s)
            2'b00:   return SPEED_10;
            2'b01:   return SPEED_100;
            default: return SPEED_1000;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_txc_phase.sv
// TXC phase generator: cnt/nib position within a byte slot, period selection
// per speed, the slot_end strobe and the TXC-high half-select for d1 and d2.
module rgmii_txc_phase
    import rgmii_tx_ddr_sched_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic   clk,
    input  logic   rst,
    input  speed_e i_speed,
    output logic   o_nib,
    output logic   o_slot_end,
    output logic   o_hi_d1,
    output logic   o_hi_d2
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_nib;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W:0]   w_p;
    logic [CNT_W:0]   w_h1;
    logic [CNT_W:0]   w_h2;

    always_comb begin
        case (i_speed)
            SPEED_10:  w_last = CNT_W'(DIV_10 - 1);
            SPEED_100: w_last = CNT_W'(DIV_100 - 1);
            default:   w_last = '0;
        endcase
    end

    // Half-cycle index h = 2*cnt (d1) or 2*cnt+1 (d2); TXC is high while h < P.
    assign w_p  = {1'b0, w_last} + 1'b1;
    assign w_h1 = {r_cnt, 1'b0};
    assign w_h2 = {r_cnt, 1'b1};

    assign o_hi_d1    = (w_h1 < w_p);
    assign o_hi_d2    = (w_h2 < w_p);
    assign o_nib      = r_nib;
    assign o_slot_end = (i_speed == SPEED_1000) || (r_nib && (r_cnt == w_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_nib <= 1'b0;
        end else if (o_slot_end) begin
            r_cnt <= '0;
            r_nib <= 1'b0;
        end else if (r_cnt == w_last) begin
            r_cnt <= '0;
            r_nib <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgmii_tx_ddr_sched.sv
// RGMII transmit scheduler: accepts one byte per slot and produces registered
// d1/d2 inputs for the TXD, TX_CTL and TXC ODDRs at 1000/100/10 Mb/s.
module rgmii_tx_ddr_sched
    import rgmii_tx_ddr_sched_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] s_data,
    input  logic       s_er,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       txctl_d1,
    output logic       txctl_d2,
    output logic       txc_d1,
    output logic       txc_d2,
    output logic [1:0] speed_act
);

    // Handshake: a byte transfers on a clk edge where s_valid and s_ready are both 1;
    // s_valid holds with stable s_data/s_er until then. s_ready marks the last cycle
    // of a slot and depends only on state, never on s_valid.

    speed_e     r_speed_act;
    logic [7:0] r_data;
    logic       r_en;
    logic       r_er;
    logic [3:0] r_txd_d1;
    logic [3:0] r_txd_d2;
    logic       r_txctl_d1;
    logic       r_txctl_d2;
    logic       r_txc_d1;
    logic       r_txc_d2;

    logic       w_nib;
    logic       w_slot_end;
    logic       w_hi_d1;
    logic       w_hi_d2;
    logic [3:0] w_nib_sel;
    logic [3:0] w_txd_d1;
    logic [3:0] w_txd_d2;

    rgmii_txc_phase #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .i_speed    (r_speed_act),
        .o_nib      (w_nib),
        .o_slot_end (w_slot_end),
        .o_hi_d1    (w_hi_d1),
        .o_hi_d2    (w_hi_d2)
    );

    assign s_ready = w_slot_end && !rst;

    // Speed is only re-sampled on an idle slot boundary, so a frame never changes rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_speed_act <= norm_speed(speed);
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_er        <= 1'b0;
        end else if (w_slot_end) begin
            if (s_valid) begin
                r_data <= s_data;
                r_en   <= 1'b1;
                r_er   <= s_er;
            end else begin
                r_data      <= 8'h00;
                r_en        <= 1'b0;
                r_er        <= 1'b0;
                r_speed_act <= norm_speed(speed);
            end
        end
    end

    always_comb begin
        w_nib_sel = w_nib ? r_data[NIB_SECOND_LSB +: 4] : r_data[NIB_FIRST_LSB +: 4];
        if (r_speed_act == SPEED_1000) begin
            w_txd_d1 = r_data[NIB_FIRST_LSB +: 4];
            w_txd_d2 = r_data[NIB_SECOND_LSB +: 4];
        end else begin
            w_txd_d1 = w_nib_sel;
            w_txd_d2 = w_nib_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd_d1   <= 4'h0;
            r_txd_d2   <= 4'h0;
            r_txctl_d1 <= 1'b0;
            r_txctl_d2 <= 1'b0;
            r_txc_d1   <= 1'b0;
            r_txc_d2   <= 1'b0;
        end else begin
            r_txd_d1   <= w_txd_d1;
            r_txd_d2   <= w_txd_d2;
            r_txctl_d1 <= w_hi_d1 ? r_en : (r_en ^ r_er);
            r_txctl_d2 <= w_hi_d2 ? r_en : (r_en ^ r_er);
            r_txc_d1   <= w_hi_d1;
            r_txc_d2   <= w_hi_d2;
        end
    end

    assign txd_d1    = r_txd_d1;
    assign txd_d2    = r_txd_d2;
    assign txctl_d1  = r_txctl_d1;
    assign txctl_d2  = r_txctl_d2;
    assign txc_d1    = r_txc_d1;
    assign txc_d2    = r_txc_d2;
    assign speed_act = r_speed_act;

endmodule

// File: tb/tb_rgmii_tx_ddr_sched.sv
// Bench for rgmii_tx_ddr_sched: per-cycle output vectors are predicted at each
// slot boundary into a queue and compared as the DUT produces them.
module tb_rgmii_tx_ddr_sched;

  localparam int DIV_100 = 5;
  localparam int DIV_10  = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] s_data;
  logic       s_er;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] txd_d1;
  logic [3:0] txd_d2;
  logic       txctl_d1;
  logic       txctl_d2;
  logic       txc_d1;
  logic       txc_d2;
  logic [1:0] speed_act;

  rgmii_tx_ddr_sched #(
    .DIV_100 (DIV_100),
    .DIV_10  (DIV_10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .speed     (speed),
    .s_data    (s_data),
    .s_er      (s_er),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .txd_d1    (txd_d1),
    .txd_d2    (txd_d2),
    .txctl_d1  (txctl_d1),
    .txctl_d2  (txctl_d2),
    .txc_d1    (txc_d1),
    .txc_d2    (txc_d2),
    .speed_act (speed_act)
  );

  // clock / reset
  always #4 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [1:0] m_speed = 2'b10;
  int m_pos = 0;
  logic last_rdy = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] tb_norm(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic int period_of(input logic [1:0] s);
    case (s)
      2'b00:   return DIV_10;
      2'b01:   return DIV_100;
      default: return 1;
    endcase
  endfunction

  function automatic int slot_len(input logic [1:0] s);
    return (s == 2'b10) ? 1 : 2 * period_of(s);
  endfunction

  // Expected {txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2} for every cycle of a slot.
  task automatic push_slot(input logic [1:0] spd, input logic [7:0] d, input logic en, input logic er);
    int p;
    int len;
    p = period_of(spd);
    len = slot_len(spd);
    for (int c = 0; c < len; c++) begin
      logic [3:0] t1;
      logic [3:0] t2;
      logic x1;
      logic x2;
      logic c1;
      logic c2;
      int cn;
      if (spd == 2'b10) begin
        t1 = d[3:0];
        t2 = d[7:4];
        x1 = 1'b1;
        x2 = 1'b0;
      end else begin
        cn = c % p;
        t1 = (c < p) ? d[3:0] : d[7:4];
        t2 = t1;
        x1 = (2 * cn < p);
        x2 = (2 * cn + 1 < p);
      end
      c1 = x1 ? en : (en ^ er);
      c2 = x2 ? en : (en ^ er);
      exp_q.push_back({t1, t2, c1, c2, x1, x2});
    end
  endtask

  // One clock cycle: check s_ready/speed_act against the model, predict, then compare outputs.
  task automatic tick(output logic acc);
    logic bnd;
    logic [11:0] e;
    acc = 1'b0;
    #1;
    last_rdy = s_ready;
    if (rst) begin
      check_val("s_ready_in_rst", s_ready, 1'b0);
      m_speed = tb_norm(speed);
      m_pos = 0;
      exp_q.delete();
      exp_q.push_back(12'h000);
      push_slot(m_speed, 8'h00, 1'b0, 1'b0);
    end else begin
      bnd = (m_pos == slot_len(m_speed) - 1);
      check_val("s_ready", s_ready, bnd);
      check_val("speed_act", speed_act, m_speed);
      if (bnd) begin
        if (s_valid) begin
          push_slot(m_speed, s_data, 1'b1, s_er);
          acc = 1'b1;
        end else begin
          m_speed = tb_norm(speed);
          push_slot(m_speed, 8'h00, 1'b0, 1'b0);
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_val("exp_q_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val("outputs", {txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2}, e);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    logic acc;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_er = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic er);
    logic acc;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_er = er;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 400);
    if (!acc) check_val("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_data = 8'h00;
    s_er = 1'b0;
  endtask

  task automatic do_reset(input int n);
    logic acc;
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick(acc);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic acc;
    rst = 1'b1;
    speed = 2'b11;
    s_data = 8'h00;
    s_er = 1'b0;
    s_valid = 1'b0;

    // 1000M streaming, speed code 2'b11 aliases to 1000M
    do_reset(3);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // mid-frame speed change is deferred to the first idle slot
    send_byte(8'h11, 1'b0);
    speed = 2'b01;
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check_val("speed_act_held_mid_frame", speed_act, 2'b10);
    idle(2);
    check_val("speed_act_after_idle", speed_act, 2'b01);

    // 100M single byte, then a long idle stretch with TXC running
    send_byte(8'h96, 1'b0);
    idle(40);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(12);

    // move to 10M on an idle boundary; byte with er=1
    speed = 2'b00;
    idle(12);
    check_val("speed_act_10m", speed_act, 2'b00);
    send_byte(8'h01, 1'b1);
    while (m_pos != 17) tick(acc);

    // reset in the middle of the slot at cnt=17
    do_reset(1);
    k = -1;
    for (int i = 0; i < 150; i++) begin
      tick(acc);
      if (last_rdy && k < 0) k = i;
    end
    check_val("first_ready_after_rst", k, 2 * DIV_10 - 1);
    send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    idle(110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgmii_tx_ddr_sched.md
# rgmii_tx_ddr_sched

Transmit-side scheduler that sequences the generic ODDR output flip-flops of an RGMII interface. It accepts one byte per slot from the MAC through a valid/ready handshake. It produces registered d1 (rising-edge half) and d2 (falling-edge half) inputs for three ODDR instances: TXD[3:0], TX_CTL and TXC. It supports 1000/100/10 Mb/s from a single 125 MHz clock.

## Interface
- DIV_100, default 5: clk cycles per TXC period at 100M (25 MHz TXC).
- DIV_10, default 50: clk cycles per TXC period at 10M (2.5 MHz TXC).
- clk  in  1  125 MHz transmit clock; also clocks the ODDRs.
- rst  in  1  reset, synchronous, active-high.
- speed  in  2  2'b00 = 10M, 2'b01 = 100M, 2'b10 or 2'b11 = 1000M.
- s_data  in  8  byte to transmit.
- s_er  in  1  transmit error for this byte.
- s_valid  in  1  byte available; held until accepted.
- s_ready  out  1  slot boundary; the byte is accepted when s_valid & s_ready.
- txd_d1 / txd_d2  out  4 each  TXD ODDR d1/d2.
- txctl_d1 / txctl_d2  out  1 each  TX_CTL ODDR d1/d2.
- txc_d1 / txc_d2  out  1 each  TXC ODDR d1/d2.
- speed_act  out  2  speed currently in effect.

## Operation
- Period P: 1 at 1000M, DIV_100 at 100M, DIV_10 at 10M.
- Byte slot length: 1 clk at 1000M; 2P clk (two TXC periods) at 10/100.
- Counters: cnt 0..P-1 (clk cycle within a TXC period) and nib 0/1 (low/high nibble period). Both wrap to 0 at the end of a slot.
- s_ready is combinational from the state: always 1 at 1000M; at 10/100 it is 1 only when nib=1 and cnt=P-1.
- Handshake: s_valid=1 with s_ready=1 latches {s_data, s_er} and sets en=1 for the next slot. s_ready=1 with s_valid=0 gives an idle next slot: en=0, er=0, data 0x00.
- 1000M output per slot:
  - txd_d1 = data[3:0], txd_d2 = data[7:4].
  - txctl_d1 = en, txctl_d2 = en ^ er.
  - txc_d1 = 1, txc_d2 = 0.
- 10/100 output: half-cycle index h = 2·cnt (d1) or 2·cnt+1 (d2).
  - txc = 1 when h < P, else 0.
  - txctl = en when h < P, else en ^ er.
  - txd_d1 = txd_d2 = data[3:0] while nib=0, data[7:4] while nib=1.
- Speed change:
  - `speed` is sampled only at a slot boundary (the s_ready cycle) when s_valid=0.
  - A new value loads speed_act and clears cnt and nib at the next edge.
  - A mid-frame speed change is therefore deferred until the first idle slot.
- Reset:
  - speed_act <= speed; cnt = 0, nib = 0, en = 0.
  - All d1/d2 outputs 0.
  - s_ready is 0 while rst=1.

## Timing
- All d1/d2 outputs are registered.
- A byte accepted at edge N drives its slot's outputs from edge N+1.
  - 1000M: for 1 cycle.
  - 10/100: for 2P cycles.
- Pin latency adds one ODDR stage downstream; not counted here.
- First s_ready after reset release: the first cycle at 1000M; cycle 2P-1 after release at 10/100.
- At 100M, P=5 is odd, so the TXC falling edge lands mid-cycle:
  - cnt 0,1 → txc 1/1; cnt 2 → 1/0; cnt 3,4 → 0/0.
- At 10M: cnt 0..24 → txc 1/1; cnt 25..49 → 0/0.
- Back-to-back bytes have no gap slots at any speed.
- Reset asserted mid-slot aborts the byte. The next cycle drives idle outputs; no partial nibble is completed.

## Structure
- Shared package/header holds the speed encodings (SPEED_10/100/1000) and the RGMII nibble-order constants.
- Natural sub-module: rgmii_txc_phase. It holds the cnt/nib counters and P selection, and emits the slot_end strobe plus the txc/ctl half-select for each d1/d2.
- The top level holds the handshake, byte/en/er registers, output muxing and the speed-change gate.
- Three oddr instances are placed by the parent, not inside this block.

## Test plan
1. 1000M, stream 0xA5, 0x3C with er=0:
   - Consecutive cycles show d1/d2 = 5/A, then C/3.
   - txctl = 1/1; txc = 1/0 every cycle; s_ready constant 1.
2. 100M, single byte 0x96:
   - 10 cycles of txd = 6/6 for 5 cycles, then 9/9 for 5 cycles.
   - txc pattern 11,11,10,00,00 repeating; txctl 1/1 throughout.
   - Then idle with txctl 0/0.
3. 10M, byte 0x01 with er=1:
   - Slot is 100 cycles long.
   - txctl = 1 for the first 25 cycles of each period, 0 for the last 25 (1^1).
   - s_ready pulses exactly once per 100 cycles.
4. Change speed from 1000M to 100M mid-frame with s_valid held 1:
   - speed_act stays 10 until the first idle slot, then becomes 01.
   - cnt restarts at 0.
5. Assert rst mid-slot at 10M, cnt=17:
   - Next cycle all outputs are 0 and s_ready is 0.
   - After release, first s_ready appears 99 cycles later.
6. Hold s_valid low at 100M:
   - txctl 0/0 and txd 0 continuously.
   - TXC keeps toggling with period 5.
